// File: rtl/reservation_station_if.sv
// Dispatch, scoreboard, result-bus and issue signals of the reservation station.
// master = surrounding pipeline, slave = the station.
interface reservation_station_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
);
   logic              dispatch_valid;
   logic              dispatch_ready;
   logic [OP_W-1:0]   dispatch_op;
   logic [4:0]        dispatch_dest;
   logic              src_a_pending;
   logic [1:0]        src_a_unit;
   logic [4:0]        src_a_row;
   logic [DATA_W-1:0] src_a_value;
   logic              src_b_pending;
   logic [1:0]        src_b_unit;
   logic [4:0]        src_b_row;
   logic [DATA_W-1:0] src_b_value;
   logic              cdb_valid;
   logic [1:0]        cdb_unit;
   logic [4:0]        cdb_row;
   logic [DATA_W-1:0] cdb_value;
   logic              sb_enablewrite;
   logic [4:0]        sb_writeaddr;
   logic [1:0]        sb_registerunit;
   logic [4:0]        sb_row;
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_op;
   logic [DATA_W-1:0] issue_a;
   logic [DATA_W-1:0] issue_b;
   logic [4:0]        issue_dest;
   logic [4:0]        issue_row;

   modport master (
      output dispatch_valid, dispatch_op, dispatch_dest,
      output src_a_pending, src_a_unit, src_a_row, src_a_value,
      output src_b_pending, src_b_unit, src_b_row, src_b_value,
      output cdb_valid, cdb_unit, cdb_row, cdb_value,
      output issue_ready,
      input  dispatch_ready, sb_enablewrite, sb_writeaddr, sb_registerunit, sb_row,
      input  issue_valid, issue_op, issue_a, issue_b, issue_dest, issue_row
   );

   modport slave (
      input  dispatch_valid, dispatch_op, dispatch_dest,
      input  src_a_pending, src_a_unit, src_a_row, src_a_value,
      input  src_b_pending, src_b_unit, src_b_row, src_b_value,
      input  cdb_valid, cdb_unit, cdb_row, cdb_value,
      input  issue_ready,
      output dispatch_ready, sb_enablewrite, sb_writeaddr, sb_registerunit, sb_row,
      output issue_valid, issue_op, issue_a, issue_b, issue_dest, issue_row
   );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions, snoops the result bus, issues ready entries.
// Optional macro RS_CDB_BYPASS_EN: capture a same-cycle result-bus value at dispatch.
module reservation_station #(
   parameter int unsigned DEPTH   = 4,
   parameter logic [1:0]  UNIT_ID = 2'd0,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned OP_W    = 4
) (
   input logic                  clock,
   input logic                  reset,
   reservation_station_if.slave rs
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TAG_W = 7;

   logic [DEPTH-1:0]  busy, rdy_a, rdy_b;
   logic [DEPTH-1:0]  hit_a, hit_b, eligible;
   logic [OP_W-1:0]   op_q    [DEPTH];
   logic [4:0]        dest_q  [DEPTH];
   logic [TAG_W-1:0]  tag_a_q [DEPTH];
   logic [TAG_W-1:0]  tag_b_q [DEPTH];
   logic [DATA_W-1:0] val_a_q [DEPTH];
   logic [DATA_W-1:0] val_b_q [DEPTH];

   logic [TAG_W-1:0]  cdb_tag;
   logic              free_found, issue_found;
   logic [IDX_W-1:0]  free_idx, issue_idx;
   logic              ready_c, accept_c, issue_fire_c;
   logic              cap_rdy_a, cap_rdy_b;
   logic [DATA_W-1:0] cap_val_a, cap_val_b;

   assign cdb_tag = {rs.cdb_unit, rs.cdb_row};

   // Result-bus match per waiting operand, and issue eligibility.
   always_comb begin
      hit_a    = '0;
      hit_b    = '0;
      eligible = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hit_a[i]    = rs.cdb_valid & busy[i] & ~rdy_a[i] & (tag_a_q[i] == cdb_tag);
         hit_b[i]    = rs.cdb_valid & busy[i] & ~rdy_b[i] & (tag_b_q[i] == cdb_tag);
         eligible[i] = busy[i] & rdy_a[i] & rdy_b[i];
      end
   end

   // Lowest-index free slot and lowest-index issuable slot (downward scan, last hit wins).
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      issue_found = 1'b0;
      issue_idx   = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (eligible[i]) begin
            issue_found = 1'b1;
            issue_idx   = IDX_W'(i);
         end
      end
   end

   // Operand capture values and dispatch readiness.
   always_comb begin
      cap_rdy_a = ~rs.src_a_pending;
      cap_rdy_b = ~rs.src_b_pending;
      cap_val_a = rs.src_a_value;
      cap_val_b = rs.src_b_value;
`ifdef RS_CDB_BYPASS_EN
      if (rs.src_a_pending && rs.cdb_valid && ({rs.src_a_unit, rs.src_a_row} == cdb_tag)) begin
         cap_rdy_a = 1'b1;
         cap_val_a = rs.cdb_value;
      end
      if (rs.src_b_pending && rs.cdb_valid && ({rs.src_b_unit, rs.src_b_row} == cdb_tag)) begin
         cap_rdy_b = 1'b1;
         cap_val_b = rs.cdb_value;
      end
      ready_c = free_found;
`else
      // Without bypass, a broadcast must never race a dispatch, so stall dispatch instead.
      ready_c = free_found & ~rs.cdb_valid;
`endif
   end

   assign accept_c     = rs.dispatch_valid & ready_c & reset;
   assign issue_fire_c = issue_found & rs.issue_ready & reset;

   assign rs.dispatch_ready  = ready_c;
   assign rs.sb_enablewrite  = accept_c;
   assign rs.sb_writeaddr    = accept_c ? rs.dispatch_dest : 5'd0;
   assign rs.sb_registerunit = UNIT_ID;
   assign rs.sb_row          = accept_c ? 5'(free_idx) : 5'd0;

   assign rs.issue_valid = issue_found;
   assign rs.issue_op    = issue_found ? op_q[issue_idx]    : '0;
   assign rs.issue_a     = issue_found ? val_a_q[issue_idx] : '0;
   assign rs.issue_b     = issue_found ? val_b_q[issue_idx] : '0;
   assign rs.issue_dest  = issue_found ? dest_q[issue_idx]  : 5'd0;
   assign rs.issue_row   = issue_found ? 5'(issue_idx)      : 5'd0;

   // Occupancy and operand-ready state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy  <= '0;
         rdy_a <= '0;
         rdy_b <= '0;
      end else begin
         rdy_a <= rdy_a | hit_a;
         rdy_b <= rdy_b | hit_b;
         if (accept_c) begin
            busy[free_idx]  <= 1'b1;
            rdy_a[free_idx] <= cap_rdy_a;
            rdy_b[free_idx] <= cap_rdy_b;
         end
         if (issue_fire_c) begin
            busy[issue_idx] <= 1'b0;
         end
      end
   end

   // Entry payload; only meaningful while busy, so no reset needed.
   always_ff @(posedge clock) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (hit_a[i]) val_a_q[i] <= rs.cdb_value;
         if (hit_b[i]) val_b_q[i] <= rs.cdb_value;
      end
      if (accept_c) begin
         op_q[free_idx]    <= rs.dispatch_op;
         dest_q[free_idx]  <= rs.dispatch_dest;
         tag_a_q[free_idx] <= {rs.src_a_unit, rs.src_a_row};
         tag_b_q[free_idx] <= {rs.src_b_unit, rs.src_b_row};
         val_a_q[free_idx] <= cap_val_a;
         val_b_q[free_idx] <= cap_val_b;
      end
   end
endmodule
